// File: rtl/arbitro_mux3_if.sv
// Purpose : request/grant bundle between the three MUX3_3 sources and arbitro_mux3.
// Latency : n/a (wires only).
// Backpr. : n/a; sources hold Req high until their Grant bit has been served.
//
// Signals:
//   Req      [2:0] level request per source (bit i = Entrada i)
//   Grant    [2:0] one-hot grant, 000 when idle
//   Controle [1:0] mux select (00/01/10), never 11
//   Valido         high while a grant is active
// Modports: master = requester side, slave = arbiter side.
interface arbitro_mux3_if;
  logic [2:0] Req;
  logic [2:0] Grant;
  logic [1:0] Controle;
  logic       Valido;

  modport master (
    output Req,
    input  Grant,
    input  Controle,
    input  Valido
  );

  modport slave (
    input  Req,
    output Grant,
    output Controle,
    output Valido
  );
endinterface

// File: rtl/arbitro_mux3.sv
// Purpose : round-robin arbiter driving the MUX3_3 select for three operand sources.
// Latency : one edge from Req to Grant/Controle/Valido; hand-over with no idle bubble.
// Backpr. : owner keeps the bus while Req is high (optionally capped by HOLD_MAX).
//
// Ports:
//   Clock   rising-edge clock
//   Resetn  asynchronous active-low reset
//   bus     arbitro_mux3_if.slave (Req in; Grant, Controle, Valido out, all registered)
// Parameter HOLD_MAX (1..15): consecutive-cycle cap for an owner while others wait.
// Build option: define ARBITRO_PREEMPCAO_EN to enable hold-time preemption;
// without it the owner keeps the grant until it drops Req and HOLD_MAX is unused.
module arbitro_mux3 #(
  parameter int HOLD_MAX = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  arbitro_mux3_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_max_invalido
    $error("arbitro_mux3: HOLD_MAX must be within 1..15");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    OCUPADO = 1'b1
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [1:0] ultimo_q, ultimo_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] controle_q, controle_d;
  logic       valido_q, valido_d;

  // Request vector padded to 4 bits so a 2-bit index is always in range.
  logic [3:0] req4;
  assign req4 = {1'b0, bus.Req};

  logic [1:0] cand1, cand2, escolhido;
  logic       achou;
  logic       dono_ativo;
  logic       outros;
  logic       preempcao;
  logic       novo_grant;

  function automatic logic [1:0] seguinte(input logic [1:0] idx);
    logic [1:0] r;
    case (idx)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Search order Ultimo+1, Ultimo+2, Ultimo (mod 3). The current owner is
  // always last, so a preemption or hand-over naturally lands on someone else.
  always_comb begin
    cand1     = seguinte(ultimo_q);
    cand2     = seguinte(cand1);
    achou     = 1'b1;
    escolhido = ultimo_q;
    if (req4[cand1]) begin
      escolhido = cand1;
    end else if (req4[cand2]) begin
      escolhido = cand2;
    end else if (req4[ultimo_q]) begin
      escolhido = ultimo_q;
    end else begin
      achou = 1'b0;
    end
  end

  // In OCUPADO, Ultimo is the owner's index.
  assign dono_ativo = req4[ultimo_q];
  assign outros     = |(req4 & ~(4'b0001 << ultimo_q));

`ifdef ARBITRO_PREEMPCAO_EN
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  logic [3:0] cnt_q, cnt_d;

  // ">=" rather than "==" so an owner already past the limit when a
  // competitor shows up is still handed off on the next edge.
  assign preempcao = (estado_q == OCUPADO) && dono_ativo && outros &&
                     (cnt_q >= HOLD_LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (novo_grant || (estado_d == IDLE)) begin
      cnt_d = 4'd0;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign preempcao = 1'b0;
`endif

  always_comb begin
    estado_d   = estado_q;
    ultimo_d   = ultimo_q;
    grant_d    = grant_q;
    controle_d = controle_q;
    valido_d   = valido_q;
    novo_grant = 1'b0;

    case (estado_q)
      IDLE: begin
        if (achou) begin
          novo_grant = 1'b1;
        end
      end
      OCUPADO: begin
        if (!dono_ativo) begin
          if (outros) begin
            novo_grant = 1'b1;
          end else begin
            // Controle keeps the last owner's code while idle.
            estado_d = IDLE;
            grant_d  = 3'b000;
            valido_d = 1'b0;
          end
        end else if (preempcao) begin
          novo_grant = 1'b1;
        end
      end
      default: begin
        estado_d = IDLE;
        grant_d  = 3'b000;
        valido_d = 1'b0;
      end
    endcase

    if (novo_grant) begin
      estado_d   = OCUPADO;
      grant_d    = 3'b001 << escolhido;
      controle_d = escolhido;
      valido_d   = 1'b1;
      ultimo_d   = escolhido;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado_q   <= IDLE;
      ultimo_q   <= 2'd2;
      grant_q    <= 3'b000;
      controle_q <= 2'b00;
      valido_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ultimo_q   <= ultimo_d;
      grant_q    <= grant_d;
      controle_q <= controle_d;
      valido_q   <= valido_d;
    end
  end

  assign bus.Grant    = grant_q;
  assign bus.Controle = controle_q;
  assign bus.Valido   = valido_q;

endmodule
